// File: rtl/statecircuit_arbiter.sv
// statecircuit_arbiter
// Round-robin front end that time-shares one two-flop state cell among NREQ
// requesters. Each accepted job clears the cell, shifts its LEN-bit word into
// input A LSB first, records the cell output Y after every step and returns
// the collected bits tagged with the requester index.

module statecircuit_arbiter #(
    parameter int NREQ = 4,
    parameter int LEN  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*LEN-1:0]        req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [LEN-1:0]             rsp_data,
    output logic                       busy
);

    localparam int IDW = $clog2(NREQ);
    // Step counter must index 0..LEN-1; keep at least one bit for LEN == 1.
    localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [IDW-1:0]    ptr_r;
    logic [CW-1:0]     step_r;
    logic [LEN-1:0]    job_r;
    logic [LEN-1:0]    res_r;
    logic [IDW-1:0]    id_r;
    logic              q0_r;
    logic              q1_r;

    logic              grant_found_s;
    logic [IDW-1:0]    grant_idx_s;
    logic [IDW:0]      cand_sum_s;
    logic [IDW:0]      cand_s;
    logic              hit_s;
    logic [IDW:0]      ptr_inc_s;
    logic [IDW-1:0]    ptr_nxt_s;

    logic              step_a_s;
    logic              step_q1_s;
    logic              step_y_s;
    logic              last_step_s;

    // Round-robin search: walk req_valid starting at the pointer, wrapping, first set bit wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum_s    = {1'b0, ptr_r} + (IDW+1)'(i);
            cand_s        = (cand_sum_s >= (IDW+1)'(NREQ)) ? (cand_sum_s - (IDW+1)'(NREQ)) : cand_sum_s;
            hit_s         = req_valid[cand_s[IDW-1:0]] & ~grant_found_s;
            grant_idx_s   = hit_s ? cand_s[IDW-1:0] : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
        ptr_inc_s = {1'b0, grant_idx_s} + (IDW+1)'(1);
        ptr_nxt_s = (ptr_inc_s == (IDW+1)'(NREQ)) ? '0 : ptr_inc_s[IDW-1:0];
    end

    // Cell step values: the input bit for this step and the post-step Y.
    always_comb begin
        step_a_s    = job_r[step_r];
        step_q1_s   = step_a_s ^ q1_r ^ q0_r;
        step_y_s    = (~q0_r) & step_q1_s;
        last_step_s = (step_r == CW'(LEN - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (last_step_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; the grant strobe is also forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_r == ST_IDLE) && grant_found_s && rst_n) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        rsp_valid = (state_r == ST_RESP);
        busy      = (state_r != ST_IDLE);
    end

    // Datapath: job capture, pointer advance, cell stepping and result collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r  <= '0;
            step_r <= '0;
            job_r  <= '0;
            res_r  <= '0;
            id_r   <= '0;
            q0_r   <= 1'b0;
            q1_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        job_r <= req_data[grant_idx_s*LEN +: LEN];
                        id_r  <= grant_idx_s;
                        ptr_r <= ptr_nxt_s;
                    end
                end
                ST_CLEAR: begin
                    q0_r   <= 1'b0;
                    q1_r   <= 1'b0;
                    step_r <= '0;
                    res_r  <= '0;
                end
                ST_RUN: begin
                    q1_r          <= step_q1_s;
                    q0_r          <= ~q0_r;
                    res_r[step_r] <= step_y_s;
                    if (!last_step_s) begin
                        step_r <= step_r + CW'(1);
                    end
                end
                ST_RESP: begin
                    // Result and id hold until the consumer takes them.
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_id   = id_r;
    assign rsp_data = res_r;

endmodule
